// File: rtl/stream_block_multiplier.sv
// stream_block_multiplier
//   Block-serial big-integer multiplier. Two BITS_IN_NUM-bit unsigned operands
//   arrive as REGISTER_SIZE-bit blocks, least significant block first. Their
//   2*BITS_IN_NUM-bit product leaves as a block stream, least significant block
//   first. One REGISTER_SIZE x REGISTER_SIZE multiply-accumulate is done per
//   cycle, working through the product one column at a time.
//
// Ports
//   clk_in     system clock, rising edge
//   rst_in     asynchronous reset, active low
//   n_in       operand A block
//   m_in       operand B block
//   valid_in   n_in/m_in carry a block pair (taken only while ready_out=1)
//   data_out   product block (registered, holds value between pulses)
//   valid_out  data_out is valid this cycle
//   final_out  marks the last product block (index 2*NB-1)
//   ready_out  block is accepting operand blocks
//
// state  | meaning
// LOAD   | storing operand block pairs into A[]/B[]
// MAC    | accumulating one A[i]*B[k-i] term of column k per cycle
// EMIT   | outputting the low block of column k, carrying the rest onward
//
// NB must be at least 2.
module stream_block_multiplier #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] n_in,
    input  logic [REGISTER_SIZE-1:0] m_in,
    input  logic                     valid_in,
    output logic [REGISTER_SIZE-1:0] data_out,
    output logic                     valid_out,
    output logic                     final_out,
    output logic                     ready_out
);

    localparam int NB    = BITS_IN_NUM / REGISTER_SIZE;
    localparam int IW    = $clog2(NB);
    localparam int KW    = $clog2(2 * NB);
    localparam int ACC_W = 2 * REGISTER_SIZE + $clog2(NB) + 1;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    localparam logic [KW-1:0] K_LAST  = KW'(2 * NB - 1);
    localparam logic [KW-1:0] K_NB_M1 = KW'(NB - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(NB - 1);

    logic [REGISTER_SIZE-1:0] a_mem [NB];
    logic [REGISTER_SIZE-1:0] b_mem [NB];

    logic [1:0]       state, state_d;
    logic [IW-1:0]    idx, idx_d;
    logic [KW-1:0]    k_cnt, k_d, k_inc;
    logic [IW-1:0]    i_cnt, i_d, j_idx;
    logic [ACC_W-1:0] acc, acc_d;
    logic [2*REGISTER_SIZE-1:0] prod;

    // Lowest and highest A index contributing to column k (i+j=k, both < NB).
    function automatic logic [IW-1:0] col_lo(input logic [KW-1:0] k);
        if (k > K_NB_M1) return IW'(k - K_NB_M1);
        else             return '0;
    endfunction

    function automatic logic [IW-1:0] col_hi(input logic [KW-1:0] k);
        if (k > K_NB_M1) return I_LAST;
        else             return IW'(k);
    endfunction

    assign k_inc = k_cnt + KW'(1);
    assign j_idx = IW'(k_cnt - KW'(i_cnt));
    assign prod  = (2*REGISTER_SIZE)'(a_mem[i_cnt]) * (2*REGISTER_SIZE)'(b_mem[j_idx]);

    always_comb begin
        state_d = state;
        idx_d   = idx;
        k_d     = k_cnt;
        i_d     = i_cnt;
        acc_d   = acc;
        case (state)
            S_LOAD: begin
                if (valid_in) begin
                    if (idx == I_LAST) begin
                        idx_d   = '0;
                        k_d     = '0;
                        i_d     = '0;
                        state_d = S_MAC;
                    end else begin
                        idx_d = idx + IW'(1);
                    end
                end
            end
            S_MAC: begin
                acc_d = acc + ACC_W'(prod);
                if (i_cnt == col_hi(k_cnt)) state_d = S_EMIT;
                else                        i_d = i_cnt + IW'(1);
            end
            S_EMIT: begin
                acc_d = acc >> REGISTER_SIZE;
                if (k_cnt == K_LAST) begin
                    acc_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    k_d = k_inc;
                    i_d = col_lo(k_inc);
                    // The top column has no terms, only the carry from below.
                    state_d = (k_inc == K_LAST) ? S_EMIT : S_MAC;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= S_LOAD;
            idx   <= '0;
            k_cnt <= '0;
            i_cnt <= '0;
            acc   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            k_cnt <= k_d;
            i_cnt <= i_d;
            acc   <= acc_d;
        end
    end

    // Outputs are registered off the next-state values so that valid_out is
    // high exactly during the EMIT cycle of each column.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            final_out <= 1'b0;
            ready_out <= 1'b1;
        end else begin
            ready_out <= (state_d == S_LOAD);
            if (state_d == S_EMIT) begin
                data_out  <= acc_d[REGISTER_SIZE-1:0];
                valid_out <= 1'b1;
                final_out <= (k_d == K_LAST);
            end else begin
                valid_out <= 1'b0;
                final_out <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (state == S_LOAD && valid_in) begin
            a_mem[idx] <= n_in;
            b_mem[idx] <= m_in;
        end
    end

endmodule

// File: tb/tb_stream_block_multiplier.sv
module tb_stream_block_multiplier;

    localparam int RS = 8;
    localparam int BN = 32;
    localparam int NB = BN / RS;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic [RS-1:0] n_in = '0;
    logic [RS-1:0] m_in = '0;
    logic          valid_in = 1'b0;
    logic [RS-1:0] data_out;
    logic          valid_out;
    logic          final_out;
    logic          ready_out;

    stream_block_multiplier #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .n_in(n_in), .m_in(m_in),
        .valid_in(valid_in), .data_out(data_out), .valid_out(valid_out),
        .final_out(final_out), .ready_out(ready_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic [RS-1:0] d;
        logic          f;
        int            c;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: full product by plain arithmetic; column k emits after
    // sum over j<=k of (term count + 1) cycles following the last input beat.
    task automatic push_expected(input logic [BN-1:0] a, input logic [BN-1:0] b, input int t);
        logic [2*BN-1:0] p;
        int when;
        int terms;
        exp_t e;
        p = {{BN{1'b0}}, a} * {{BN{1'b0}}, b};
        when = t;
        for (int k = 0; k < 2*NB; k++) begin
            if (k <= 2*NB-2) terms = ((k < 2*NB-2-k) ? k : 2*NB-2-k) + 1;
            else             terms = 0;
            when += terms + 1;
            e.d = p[RS*k +: RS];
            e.f = (k == 2*NB-1);
            e.c = when;
            exp_q.push_back(e);
        end
    endtask

    // gap < 0 selects a random 0..3 idle cycles before each beat.
    task automatic send_op(input logic [BN-1:0] a, input logic [BN-1:0] b, input int gap,
                           output int t_last);
        int g;
        t_last = 0;
        for (int k = 0; k < NB; k++) begin
            g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
            if (k == 0) g = 0;
            repeat (g) begin
                @(negedge clk_in);
                valid_in = 1'b0;
                n_in = RS'($urandom);
                m_in = RS'($urandom);
            end
            @(negedge clk_in);
            valid_in = 1'b1;
            n_in = a[RS*k +: RS];
            m_in = b[RS*k +: RS];
            t_last = cyc;
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        push_expected(a, b, t_last);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk_in);
        #1;
        chk("ready_after_final", 64'(ready_out), 64'd1);
        repeat (3) @(negedge clk_in);
    endtask

    // Monitor / scoreboard
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in && final_out && !valid_out)
            chk("final_without_valid", 64'(final_out), 64'd0);
        if (rst_in && valid_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'(valid_out), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data_out", 64'(data_out), 64'(e.d));
                chk("final_out", 64'(final_out), 64'(e.f));
                chk("emit_cycle", 64'(cyc), 64'(e.c));
                chk("ready_while_emit", 64'(ready_out), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [BN-1:0] ra, rb;

        repeat (3) @(negedge clk_in);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_final_out", 64'(final_out), 64'd0);
        chk("rst_ready_out", 64'(ready_out), 64'd1);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);

        send_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, t);
        wait_idle();
        send_op(32'h00000001, 32'h89ABCDEF, 0, t);
        wait_idle();
        send_op(32'h00000000, 32'hDEADBEEF, 0, t);
        wait_idle();
        send_op(32'h12345678, 32'h9ABCDEF0, 3, t);
        wait_idle();

        // Garbage while busy must be ignored.
        send_op(32'hCAFEF00D, 32'h0BADC0DE, 0, t);
        repeat (18) begin
            @(negedge clk_in);
            valid_in = 1'($urandom_range(1, 0));
            n_in = RS'($urandom);
            m_in = RS'($urandom);
            #1;
            chk("ready_while_busy", 64'(ready_out), 64'd0);
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        wait_idle();
        send_op(32'h00010002, 32'h00030004, 0, t);
        wait_idle();

        // Reset during column 3 emit (t + 2+3+4+5).
        send_op(32'h87654321, 32'hFEDCBA98, 0, t);
        while (cyc < t + 14) @(negedge clk_in);
        #2;
        chk("col3_valid_before_reset", 64'(valid_out), 64'd1);
        rst_in = 1'b0;
        #1;
        chk("abort_data_out", 64'(data_out), 64'd0);
        chk("abort_valid_out", 64'(valid_out), 64'd0);
        chk("abort_final_out", 64'(final_out), 64'd0);
        chk("abort_ready_out", 64'(ready_out), 64'd1);
        exp_q.delete();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (30) @(negedge clk_in);
        send_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, t);
        wait_idle();

        for (int r = 0; r < 6; r++) begin
            ra = $urandom;
            rb = $urandom;
            send_op(ra, rb, -1, t);
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
